riscv_lsu: RTL and testbench
============================

RISCV_LSU -- requirements
Module: riscv_lsu

Interface
REQ-001 Parameter P_TIMEOUT, default 255, maximum cycles the block waits for i_dbus_ack in REQ before declaring a fault; range 1..255.
REQ-002 The data width SHALL be `XLEN from riscv_configs.v, fixed at 32.
REQ-003 i_clk  in  1  single clock; all state updates on its rising edge.
REQ-004 i_rstn  in  1  reset, asynchronous and active-low.
REQ-005 i_ctrl_mem_wr_enE  in  1  store request from the execute stage.
REQ-006 i_ctrl_mem_rd_enE  in  1  load request from the execute stage.
REQ-007 i_ctrl_funct3E  in  3  access size and sign (LB/LH/LW/LBU/LHU, SB/SH/SW encodings).
REQ-008 i_alu_resultE  in  `XLEN  byte address.
REQ-009 i_mem_writedataE  in  `XLEN  forwarded store data, LSB-aligned.
REQ-010 o_dbus_req  out  1  bus request; held high until acknowledged.
REQ-011 o_dbus_we  out  1  1 = write, 0 = read.
REQ-012 o_dbus_addr  out  `XLEN  word address; bits [1:0] are always 0.
REQ-013 o_dbus_wdata  out  `XLEN  store data shifted to the byte lane.
REQ-014 o_dbus_be  out  4  byte enables.
REQ-015 i_dbus_ack  in  1  responder completes the transfer this cycle.
REQ-016 i_dbus_err  in  1  bus error; sampled only when i_dbus_ack=1.
REQ-017 i_dbus_rdata  in  `XLEN  read word; valid only when i_dbus_ack=1.
REQ-018 o_lsu_stall  out  1  freezes the fetch, decode and execute pipeline registers.
REQ-019 o_lsu_rdata  out  `XLEN  aligned and extended load result.
REQ-020 o_lsu_rdata_valid  out  1  one-cycle strobe qualifying o_lsu_rdata.
REQ-021 o_lsu_fault  out  1  one-cycle strobe for misalign, illegal funct3, bus error or timeout.

Function
REQ-022 FSM states: IDLE, REQ, DONE.
REQ-023 In IDLE, an access is pending when rd_en or wr_en is 1; if both are 1 the access SHALL be a write.
REQ-024 A pending access SHALL assert o_lsu_stall combinationally in the same cycle.
REQ-025 The block SHALL detect a misalign (half with addr[0]=1; word with addr[1:0]!=0) or an illegal funct3. On detection it SHALL issue no bus request and go IDLE->DONE with the fault flagged.
REQ-026 For a legal pending access, the block SHALL go IDLE->REQ at the next edge and register addr, we, be and wdata from the inputs.
REQ-027 The block SHALL derive be from funct3 and addr[1:0]: byte 4'b0001<<a; half 4'b0011<<a; word 4'b1111.
REQ-028 The block SHALL derive wdata as: byte replicated ×4; half replicated ×2; word unchanged.
REQ-029 In REQ, o_dbus_req=1, o_lsu_stall=1, and all bus outputs SHALL hold stable until i_dbus_ack=1.
REQ-030 On i_dbus_ack in REQ, the block SHALL go to DONE and capture i_dbus_rdata and i_dbus_err; o_dbus_req SHALL be 0 in DONE.
REQ-031 A timeout counter SHALL clear on entry to REQ and increment each REQ cycle without ack. When it reaches P_TIMEOUT the block SHALL drop the request, go to DONE and flag a fault.
REQ-032 In DONE, o_lsu_stall=0 so the pipeline advances at this edge, and the next state is IDLE. No new access SHALL be launched from DONE.
REQ-033 In DONE, o_lsu_rdata_valid=1 for a load without fault; o_lsu_fault=1 for any fault, with rdata_valid=0.
REQ-034 Load extraction SHALL use the registered addr[1:0]: LB/LBU take byte a, LH/LHU take half a[1], LW takes the full word; signed loads SHALL sign-extend and unsigned loads SHALL zero-extend.
REQ-035 Minimum latency: a legal access presented in cycle 0 with ack in cycle 1 gives the DONE strobe in cycle 2, i.e. 2 stall cycles.
REQ-036 i_dbus_ack outside REQ SHALL be ignored.

Reset
REQ-037 While i_rstn=0, all of the following SHALL be 0: state=IDLE, o_dbus_req, o_dbus_we, o_dbus_addr, o_dbus_wdata, o_dbus_be, o_lsu_rdata, o_lsu_rdata_valid, o_lsu_fault, and the counter.
REQ-038 While i_rstn=0, o_lsu_stall SHALL be 0 regardless of the request inputs.
REQ-039 Reset asserted in REQ SHALL drop o_dbus_req immediately, without waiting for a clock edge; the abandoned transfer SHALL NOT be retried.

Verification
REQ-040 Stimulus: SW, addr 0x100, data 0xDEADBEEF, ack after 3 cycles. Response: addr=0x100, be=1111, wdata=0xDEADBEEF, stall high 4 cycles, no rdata_valid.
REQ-041 Stimulus: LB, addr 0x203, rdata 0x80FF_FF7F. Response: o_lsu_rdata=0xFFFFFF80 with rdata_valid. Same with LBU: 0x00000080.
REQ-042 Stimulus: SH, addr 0x102, data 0x1234ABCD. Response: be=1100, wdata=0xABCDABCD.
REQ-043 Stimulus: LW, addr 0x101. Response: no o_dbus_req, 1 stall cycle, then fault strobe.
REQ-044 Stimulus: P_TIMEOUT=4, ack never asserted. Response: req high 4 cycles, then fault; ack with err=1 also gives a fault.
REQ-045 Stimulus: i_rstn pulsed low mid-REQ. Response: req=0 asynchronously, state IDLE, a later access runs normally.

Source files
------------

// File: rtl/riscv_lsu.sv
// Load/store unit: turns execute-stage memory requests into single word-aligned data-bus
// transfers. The pipeline stalls until the transfer completes, faults or times out.
`ifndef XLEN
`define XLEN 32
`endif

module riscv_lsu #(
    parameter int unsigned P_TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_ctrl_mem_wr_enE,
    input  logic              i_ctrl_mem_rd_enE,
    input  logic [2:0]        i_ctrl_funct3E,
    input  logic [`XLEN-1:0]  i_alu_resultE,
    input  logic [`XLEN-1:0]  i_mem_writedataE,
    output logic              o_dbus_req,
    output logic              o_dbus_we,
    output logic [`XLEN-1:0]  o_dbus_addr,
    output logic [`XLEN-1:0]  o_dbus_wdata,
    output logic [3:0]        o_dbus_be,
    input  logic              i_dbus_ack,
    input  logic              i_dbus_err,
    input  logic [`XLEN-1:0]  i_dbus_rdata,
    output logic              o_lsu_stall,
    output logic [`XLEN-1:0]  o_lsu_rdata,
    output logic              o_lsu_rdata_valid,
    output logic              o_lsu_fault
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StDone = 2'd2
    } lsuState_e;

    lsuState_e         state;
    logic [7:0]        timeoutCnt;
    logic [1:0]        addrLo;
    logic [2:0]        funct3Reg;

    logic              pending;
    logic              illegal;
    logic              misalign;
    logic [1:0]        reqAddrLo;
    logic [3:0]        nextBe;
    logic [`XLEN-1:0]  nextWdata;
    logic [7:0]        loadByte;
    logic [15:0]       loadHalf;
    logic [`XLEN-1:0]  loadData;

    assign pending   = i_ctrl_mem_wr_enE | i_ctrl_mem_rd_enE;
    assign reqAddrLo = i_alu_resultE[1:0];

    // Request decode: lane enables, replicated store data and fault detection.
    always_comb begin
        illegal   = 1'b0;
        misalign  = 1'b0;
        nextBe    = 4'b0000;
        nextWdata = i_mem_writedataE;
        case (i_ctrl_funct3E[1:0])
            2'b00: begin
                nextBe    = 4'b0001 << reqAddrLo;
                nextWdata = {4{i_mem_writedataE[7:0]}};
            end
            2'b01: begin
                nextBe    = 4'b0011 << reqAddrLo;
                nextWdata = {2{i_mem_writedataE[15:0]}};
                misalign  = reqAddrLo[0];
            end
            2'b10: begin
                nextBe   = 4'b1111;
                misalign = (reqAddrLo != 2'b00);
                illegal  = i_ctrl_funct3E[2];
            end
            default: illegal = 1'b1;
        endcase
        // Stores have no unsigned variants; writes win when both enables are set.
        if (i_ctrl_mem_wr_enE && i_ctrl_funct3E[2]) begin
            illegal = 1'b1;
        end
    end

    // Load extraction uses the address captured with the request.
    always_comb begin
        case (addrLo)
            2'd0:    loadByte = i_dbus_rdata[7:0];
            2'd1:    loadByte = i_dbus_rdata[15:8];
            2'd2:    loadByte = i_dbus_rdata[23:16];
            default: loadByte = i_dbus_rdata[31:24];
        endcase
        loadHalf = addrLo[1] ? i_dbus_rdata[31:16] : i_dbus_rdata[15:0];
        case (funct3Reg)
            3'b000:  loadData = {{24{loadByte[7]}}, loadByte};
            3'b001:  loadData = {{16{loadHalf[15]}}, loadHalf};
            3'b100:  loadData = {24'd0, loadByte};
            3'b101:  loadData = {16'd0, loadHalf};
            default: loadData = i_dbus_rdata;
        endcase
    end

    assign o_lsu_stall = i_rstn & (((state == StIdle) & pending) | (state == StReq));

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state             <= StIdle;
            timeoutCnt        <= 8'd0;
            addrLo            <= 2'd0;
            funct3Reg         <= 3'd0;
            o_dbus_req        <= 1'b0;
            o_dbus_we         <= 1'b0;
            o_dbus_addr       <= '0;
            o_dbus_wdata      <= '0;
            o_dbus_be         <= 4'b0000;
            o_lsu_rdata       <= '0;
            o_lsu_rdata_valid <= 1'b0;
            o_lsu_fault       <= 1'b0;
        end else begin
            o_lsu_rdata_valid <= 1'b0;
            o_lsu_fault       <= 1'b0;
            case (state)
                StIdle: begin
                    if (pending) begin
                        if (illegal || misalign) begin
                            state       <= StDone;
                            o_lsu_fault <= 1'b1;
                        end else begin
                            state        <= StReq;
                            timeoutCnt   <= 8'd0;
                            o_dbus_req   <= 1'b1;
                            o_dbus_we    <= i_ctrl_mem_wr_enE;
                            o_dbus_addr  <= {i_alu_resultE[`XLEN-1:2], 2'b00};
                            o_dbus_be    <= nextBe;
                            o_dbus_wdata <= nextWdata;
                            addrLo       <= reqAddrLo;
                            funct3Reg    <= i_ctrl_funct3E;
                        end
                    end
                end
                StReq: begin
                    if (i_dbus_ack) begin
                        state      <= StDone;
                        o_dbus_req <= 1'b0;
                        if (i_dbus_err) begin
                            o_lsu_fault <= 1'b1;
                        end else if (!o_dbus_we) begin
                            o_lsu_rdata       <= loadData;
                            o_lsu_rdata_valid <= 1'b1;
                        end
                    end else if (timeoutCnt == 8'(P_TIMEOUT - 1)) begin
                        state       <= StDone;
                        o_dbus_req  <= 1'b0;
                        o_lsu_fault <= 1'b1;
                    end else begin
                        timeoutCnt <= timeoutCnt + 8'd1;
                    end
                end
                // The pipeline advances this cycle; the held instruction must not relaunch.
                StDone:  state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: table of single accesses plus reset and stray-ack sequences.
module tb_riscv_lsu;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        wrEn = 1'b0;
    logic        rdEn = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] aluRes = 32'd0;
    logic [31:0] wrData = 32'd0;
    logic        busReq;
    logic        busWe;
    logic [31:0] busAddr;
    logic [31:0] busWdata;
    logic [3:0]  busBe;
    logic        busAck = 1'b0;
    logic        busErr = 1'b0;
    logic [31:0] busRdata = 32'hFFFF_FFFF;
    logic        stall;
    logic [31:0] lsuRdata;
    logic        lsuValid;
    logic        lsuFault;

    int total = 0;
    int bad = 0;

    riscv_lsu #(.P_TIMEOUT(4)) dut (
        .i_clk             (clk),
        .i_rstn            (rstn),
        .i_ctrl_mem_wr_enE (wrEn),
        .i_ctrl_mem_rd_enE (rdEn),
        .i_ctrl_funct3E    (funct3),
        .i_alu_resultE     (aluRes),
        .i_mem_writedataE  (wrData),
        .o_dbus_req        (busReq),
        .o_dbus_we         (busWe),
        .o_dbus_addr       (busAddr),
        .o_dbus_wdata      (busWdata),
        .o_dbus_be         (busBe),
        .i_dbus_ack        (busAck),
        .i_dbus_err        (busErr),
        .i_dbus_rdata      (busRdata),
        .o_lsu_stall       (stall),
        .o_lsu_rdata       (lsuRdata),
        .o_lsu_rdata_valid (lsuValid),
        .o_lsu_fault       (lsuFault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        re;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ackAfter;  // REQ cycle carrying the ack; 0 = never
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  expBe;
        logic [31:0] expWdata;
        logic [31:0] expRdata;
        int          expReq;
        int          expStall;
        logic        expValid;
        logic        expFault;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(logic we, logic re, logic [2:0] f3, logic [31:0] addr,
                                logic [31:0] wdata, int ackAfter, logic [31:0] rdata,
                                logic err, logic [3:0] expBe, logic [31:0] expWdata,
                                logic [31:0] expRdata, int expReq, int expStall,
                                logic expValid, logic expFault);
        vec_t v;
        v.we = we; v.re = re; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.ackAfter = ackAfter; v.rdata = rdata; v.err = err; v.expBe = expBe;
        v.expWdata = expWdata; v.expRdata = expRdata; v.expReq = expReq;
        v.expStall = expStall; v.expValid = expValid; v.expFault = expFault;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic runVec(input int idx, input vec_t v);
        int  stallCnt = 0;
        int  reqCnt = 0;
        bit  done = 1'b0;
        @(negedge clk);
        wrEn = v.we; rdEn = v.re; funct3 = v.f3; aluRes = v.addr; wrData = v.wdata;
        #1;
        for (int k = 0; k < 40 && !done; k++) begin
            if (!stall) begin
                done = 1'b1;
                check($sformatf("v%0d stall cycles", idx), 32'(stallCnt), 32'(v.expStall));
                check($sformatf("v%0d req cycles", idx), 32'(reqCnt), 32'(v.expReq));
                check($sformatf("v%0d rdata_valid", idx), 32'(lsuValid), 32'(v.expValid));
                check($sformatf("v%0d fault", idx), 32'(lsuFault), 32'(v.expFault));
                check($sformatf("v%0d req in done", idx), 32'(busReq), 32'd0);
                if (v.expValid) check($sformatf("v%0d rdata", idx), lsuRdata, v.expRdata);
            end else begin
                stallCnt++;
                if (busReq) begin
                    reqCnt++;
                    check($sformatf("v%0d we", idx), 32'(busWe), 32'(v.we));
                    check($sformatf("v%0d addr", idx), busAddr, {v.addr[31:2], 2'b00});
                    check($sformatf("v%0d be", idx), 32'(busBe), 32'(v.expBe));
                    if (v.we) check($sformatf("v%0d wdata", idx), busWdata, v.expWdata);
                    if (reqCnt == v.ackAfter) begin
                        busAck = 1'b1; busRdata = v.rdata; busErr = v.err;
                    end
                end
                @(negedge clk);
                busAck = 1'b0; busRdata = 32'hFFFF_FFFF; busErr = 1'b0;
                #1;
            end
        end
        if (!done) check($sformatf("v%0d completion", idx), 32'd0, 32'd1);
        wrEn = 1'b0; rdEn = 1'b0;
    endtask

    initial begin
        vecs[0]  = mk(1, 0, 3'b010, 32'h100, 32'hDEADBEEF, 3, 0, 0, 4'b1111, 32'hDEADBEEF,
                      0, 3, 4, 0, 0);
        vecs[1]  = mk(0, 1, 3'b000, 32'h203, 0, 1, 32'h80FF_FF7F, 0, 4'b1000, 0,
                      32'hFFFF_FF80, 1, 2, 1, 0);
        vecs[2]  = mk(0, 1, 3'b100, 32'h203, 0, 1, 32'h80FF_FF7F, 0, 4'b1000, 0,
                      32'h0000_0080, 1, 2, 1, 0);
        vecs[3]  = mk(1, 0, 3'b001, 32'h102, 32'h1234ABCD, 1, 0, 0, 4'b1100, 32'hABCDABCD,
                      0, 1, 2, 0, 0);
        vecs[4]  = mk(0, 1, 3'b010, 32'h101, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        vecs[5]  = mk(0, 1, 3'b001, 32'h206, 0, 1, 32'h8001_1234, 0, 4'b1100, 0,
                      32'hFFFF_8001, 1, 2, 1, 0);
        vecs[6]  = mk(0, 1, 3'b101, 32'h204, 0, 1, 32'h8001_F234, 0, 4'b0011, 0,
                      32'h0000_F234, 1, 2, 1, 0);
        vecs[7]  = mk(0, 1, 3'b010, 32'h300, 0, 2, 32'hCAFE_F00D, 0, 4'b1111, 0,
                      32'hCAFE_F00D, 2, 3, 1, 0);
        vecs[8]  = mk(1, 0, 3'b000, 32'h301, 32'h0000_00A5, 1, 0, 0, 4'b0010, 32'hA5A5_A5A5,
                      0, 1, 2, 0, 0);
        vecs[9]  = mk(0, 1, 3'b010, 32'h400, 0, 0, 0, 0, 4'b1111, 0, 0, 4, 5, 0, 1);
        vecs[10] = mk(0, 1, 3'b010, 32'h404, 0, 1, 32'h1234_5678, 1, 4'b1111, 0, 0, 1, 2, 0, 1);
        vecs[11] = mk(0, 1, 3'b011, 32'h008, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        vecs[12] = mk(1, 0, 3'b100, 32'h008, 32'h55, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        vecs[13] = mk(1, 1, 3'b010, 32'h10C, 32'h1122_3344, 1, 0, 0, 4'b1111, 32'h1122_3344,
                      0, 1, 2, 0, 0);
        vecs[14] = mk(0, 1, 3'b001, 32'h201, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        vecs[15] = mk(0, 1, 3'b000, 32'h201, 0, 1, 32'h0000_7F00, 0, 4'b0010, 0,
                      32'h0000_007F, 1, 2, 1, 0);
        vecs[16] = mk(1, 0, 3'b010, 32'h102, 32'h0BAD_0BAD, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);

        // Reset state, with a request pending on the inputs.
        rdEn = 1'b1; funct3 = 3'b010; aluRes = 32'h40;
        #22;
        check("reset stall", 32'(stall), 32'd0);
        check("reset req", 32'(busReq), 32'd0);
        check("reset we", 32'(busWe), 32'd0);
        check("reset addr", busAddr, 32'd0);
        check("reset wdata", busWdata, 32'd0);
        check("reset be", 32'(busBe), 32'd0);
        check("reset rdata", lsuRdata, 32'd0);
        check("reset valid", 32'(lsuValid), 32'd0);
        check("reset fault", 32'(lsuFault), 32'd0);
        @(negedge clk);
        rdEn = 1'b0;
        rstn = 1'b1;

        foreach (vecs[i]) runVec(i, vecs[i]);

        // Stray acks while idle must be ignored.
        @(negedge clk);
        busAck = 1'b1; busRdata = 32'h1357_9BDF;
        repeat (2) begin
            @(negedge clk);
            #1;
            check("stray ack req", 32'(busReq), 32'd0);
            check("stray ack valid", 32'(lsuValid), 32'd0);
            check("stray ack fault", 32'(lsuFault), 32'd0);
        end
        busAck = 1'b0; busRdata = 32'hFFFF_FFFF;

        // Reset pulsed mid-transfer drops the request at once and is not retried.
        @(negedge clk);
        rdEn = 1'b1; funct3 = 3'b010; aluRes = 32'h500;
        repeat (2) @(negedge clk);
        #1;
        check("pre-reset req", 32'(busReq), 32'd1);
        #2 rstn = 1'b0;
        #1;
        check("async reset req", 32'(busReq), 32'd0);
        check("async reset stall", 32'(stall), 32'd0);
        check("async reset addr", busAddr, 32'd0);
        @(negedge clk);
        rdEn = 1'b0;
        rstn = 1'b1;
        @(negedge clk);
        #1;
        check("no retry req", 32'(busReq), 32'd0);
        check("no retry stall", 32'(stall), 32'd0);
        runVec(100, vecs[7]);
        runVec(101, vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1);
    end

endmodule
